// File: rtl/dmem_responder_pkg.sv
// Shared types and constants for the multi-cycle LEGv8 data-memory responder.
package dmem_responder_pkg;

  localparam int unsigned ADDR_W     = 64;
  localparam int unsigned DATA_W     = 64;
  localparam int unsigned DW_BYTES   = 8;
  localparam int unsigned ADDR_SHIFT = 3;
  localparam int unsigned CNT_W      = 4;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } dmemState_t;

  typedef struct packed {
    logic              memRead;
    logic              memWrite;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] writeData;
  } dmemReq_t;

endpackage

// File: rtl/dmem_responder_if.sv
// Req/Ack bus between the LEGv8 datapath (master) and the data-memory responder (slave).
interface dmem_responder_if;
  import dmem_responder_pkg::*;

  logic              Req;
  logic              MemRead;
  logic              MemWrite;
  logic [ADDR_W-1:0] Address;
  logic [DATA_W-1:0] WriteData;
  logic [DATA_W-1:0] ReadData;
  logic              Ack;
  logic              Busy;
  logic              Error;

  modport master (
    output Req, MemRead, MemWrite, Address, WriteData,
    input  ReadData, Ack, Busy, Error
  );

  modport slave (
    input  Req, MemRead, MemWrite, Address, WriteData,
    output ReadData, Ack, Busy, Error
  );

endinterface

// File: rtl/dmem_array.sv
// DEPTH x 64 storage with a synchronous write and a registered read port.
module dmem_array
  import dmem_responder_pkg::*;
#(
  parameter  int unsigned DEPTH = 128,
  localparam int unsigned IDX_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wrEn,
  input  logic              rdEn,
  input  logic              rdClr,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] wrData,
  output logic [DATA_W-1:0] rdData
);

  typedef logic [DEPTH-1:0][DATA_W-1:0] memArr_t;

  // Power-on image: doubleword i holds the value i.
  function automatic memArr_t initMem();
    memArr_t m;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      m[i] = DATA_W'(i);
    end
    return m;
  endfunction

  memArr_t mem = initMem();

  always_ff @(posedge clk) begin
    if (wrEn) begin
      mem[idx] <= wrData;
    end
  end

  // Read register doubles as the response data holding register.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdData <= '0;
    end else if (rdClr) begin
      rdData <= '0;
    end else if (rdEn) begin
      rdData <= mem[idx];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory target: Req/Ack handshake, programmable wait states, illegal-access flagging.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int unsigned       DEPTH       = 128,
  parameter int unsigned       WAIT_STATES = 2,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0
) (
  input  logic Clock,
  input  logic Reset,
  dmem_responder_if.slave bus
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  dmemState_t        state, nextState;
  logic [CNT_W-1:0]  waitCnt, waitCntNext;
  dmemReq_t          held, cur;
  logic [ADDR_W-1:0] offset;
  logic              legal;
  logic              ackQ, busyQ, errQ;
  logic              ackD, busyD, errD;
  logic              wrEn, rdEn, rdClr;
  logic [DATA_W-1:0] rdData;

  // Live inputs on the accepting edge (matters for zero wait states), latched copy afterwards.
  always_comb begin
    cur = held;
    if (state == IDLE) begin
      cur.memRead   = bus.MemRead;
      cur.memWrite  = bus.MemWrite;
      cur.address   = bus.Address;
      cur.writeData = bus.WriteData;
    end
    offset = cur.address - BASE_ADDR;
    legal  = ((cur.address & ADDR_W'(DW_BYTES - 1)) == '0)
          && (cur.address >= BASE_ADDR)
          && ((offset >> ADDR_SHIFT) < ADDR_W'(DEPTH))
          && (cur.memRead ^ cur.memWrite);
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state   <= IDLE;
      waitCnt <= '0;
      held    <= '0;
      ackQ    <= 1'b0;
      busyQ   <= 1'b0;
      errQ    <= 1'b0;
    end else begin
      state   <= nextState;
      waitCnt <= waitCntNext;
      if (state == IDLE && bus.Req) begin
        held <= cur;
      end
      ackQ  <= ackD;
      busyQ <= busyD;
      errQ  <= errD;
    end
  end

  always_comb begin
    nextState   = state;
    waitCntNext = waitCnt;
    unique case (state)
      IDLE: begin
        if (bus.Req) begin
          if (WAIT_STATES == 0) begin
            nextState = RESP;
          end else begin
            nextState   = WAIT;
            waitCntNext = CNT_W'(WAIT_STATES - 1);
          end
        end
      end
      WAIT: begin
        if (waitCnt == '0) begin
          nextState = RESP;
        end else begin
          waitCntNext = waitCnt - CNT_W'(1);
        end
      end
      RESP:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Array access happens on the edge entering RESP; a store never commits under reset.
  always_comb begin
    ackD  = (nextState == RESP);
    busyD = (nextState != IDLE);
    errD  = ackD && !legal;
    wrEn  = ackD && legal && cur.memWrite && !Reset;
    rdEn  = ackD && legal && cur.memRead;
    rdClr = ackD && !legal;
  end

  dmem_array #(.DEPTH(DEPTH)) uArray (
    .clk    (Clock),
    .rst    (Reset),
    .wrEn   (wrEn),
    .rdEn   (rdEn),
    .rdClr  (rdClr),
    .idx    (offset[ADDR_SHIFT +: IDX_W]),
    .wrData (cur.writeData),
    .rdData (rdData)
  );

  assign bus.Ack      = ackQ;
  assign bus.Busy     = busyQ;
  assign bus.Error    = errQ;
  assign bus.ReadData = rdData;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: three instances covering 2, 0 and 1 wait states and a non-zero base.
module tb_dmem_responder;

  logic Clock;
  logic Reset;
  int   nAsserts = 0;
  int   nFails   = 0;

  dmem_responder_if busA ();
  dmem_responder_if busB ();
  dmem_responder_if busC ();

  dmem_responder #(.DEPTH(128), .WAIT_STATES(2), .BASE_ADDR(64'h0)) dutA (
    .Clock(Clock), .Reset(Reset), .bus(busA));
  dmem_responder #(.DEPTH(128), .WAIT_STATES(0), .BASE_ADDR(64'h0)) dutB (
    .Clock(Clock), .Reset(Reset), .bus(busB));
  dmem_responder #(.DEPTH(16), .WAIT_STATES(1), .BASE_ADDR(64'h100)) dutC (
    .Clock(Clock), .Reset(Reset), .bus(busC));

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nAsserts++;
    if (got !== exp) begin
      nFails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic setReq(input int sel, input logic req, input logic rd, input logic wr,
                        input logic [63:0] addr, input logic [63:0] data);
    case (sel)
      0: begin busA.Req = req; busA.MemRead = rd; busA.MemWrite = wr; busA.Address = addr; busA.WriteData = data; end
      1: begin busB.Req = req; busB.MemRead = rd; busB.MemWrite = wr; busB.Address = addr; busB.WriteData = data; end
      default: begin busC.Req = req; busC.MemRead = rd; busC.MemWrite = wr; busC.Address = addr; busC.WriteData = data; end
    endcase
  endtask

  function automatic logic ackOf(input int sel);
    return (sel == 0) ? busA.Ack : (sel == 1) ? busB.Ack : busC.Ack;
  endfunction
  function automatic logic busyOf(input int sel);
    return (sel == 0) ? busA.Busy : (sel == 1) ? busB.Busy : busC.Busy;
  endfunction
  function automatic logic errOf(input int sel);
    return (sel == 0) ? busA.Error : (sel == 1) ? busB.Error : busC.Error;
  endfunction
  function automatic logic [63:0] rdOf(input int sel);
    return (sel == 0) ? busA.ReadData : (sel == 1) ? busB.ReadData : busC.ReadData;
  endfunction

  // One request; inputs are scrambled right after acceptance to prove they were latched.
  task automatic expectTxn(input int sel, input string tag, input logic rd, input logic wr,
                           input logic [63:0] addr, input logic [63:0] data,
                           input logic [63:0] expData, input logic expErr, input int expLat);
    int   lat;
    logic busyGap;
    busyGap = 1'b0;
    setReq(sel, 1'b1, rd, wr, addr, data);
    @(posedge Clock); #1;
    setReq(sel, 1'b0, wr, rd, ~addr, ~data);
    lat = 1;
    while (!ackOf(sel) && lat < 40) begin
      if (!busyOf(sel)) busyGap = 1'b1;
      @(posedge Clock); #1;
      lat++;
    end
    if (!busyOf(sel)) busyGap = 1'b1;
    checkVal({tag, " latency"}, 64'(lat), 64'(expLat));
    checkVal({tag, " data"}, rdOf(sel), expData);
    checkVal({tag, " error"}, 64'(errOf(sel)), 64'(expErr));
    checkVal({tag, " busy gap"}, 64'(busyGap), 64'd0);
    @(posedge Clock); #1;
    checkVal({tag, " ack pulse"}, 64'(ackOf(sel)), 64'd0);
    checkVal({tag, " busy drop"}, 64'(busyOf(sel)), 64'd0);
    checkVal({tag, " error low"}, 64'(errOf(sel)), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic ackSeen;
    for (int s = 0; s < 3; s++) setReq(s, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0);
    Reset = 1'b1;
    repeat (3) @(posedge Clock);
    #1;
    checkVal("reset ack", 64'(busA.Ack), 64'd0);
    checkVal("reset busy", 64'(busA.Busy), 64'd0);
    checkVal("reset error", 64'(busA.Error), 64'd0);
    checkVal("reset data", busA.ReadData, 64'd0);
    checkVal("reset busy B", 64'(busB.Busy), 64'd0);
    Reset = 1'b0;

    // Two wait states, base 0
    expectTxn(0, "ld 0x18",     1, 0, 64'h18,  64'h0,        64'd3,        0, 3);
    expectTxn(0, "st 0x40",     0, 1, 64'h40,  64'hDEADBEEF, 64'd3,        0, 3);
    expectTxn(0, "ld 0x40",     1, 0, 64'h40,  64'h0,        64'hDEADBEEF, 0, 3);
    expectTxn(0, "ld 0x38",     1, 0, 64'h38,  64'h0,        64'd7,        0, 3);
    expectTxn(0, "ld misalign", 1, 0, 64'h1C,  64'h0,        64'd0,        1, 3);
    expectTxn(0, "ld top+1",    1, 0, 64'h400, 64'h0,        64'd0,        1, 3);
    expectTxn(0, "st top+1",    0, 1, 64'h400, 64'h55,       64'd0,        1, 3);
    expectTxn(0, "ld 0x0",      1, 0, 64'h0,   64'h0,        64'd0,        0, 3);
    expectTxn(0, "rd+wr",       1, 1, 64'h20,  64'h99,       64'd0,        1, 3);
    expectTxn(0, "no op",       0, 0, 64'h28,  64'h0,        64'd0,        1, 3);
    expectTxn(0, "ld 0x20",     1, 0, 64'h20,  64'h0,        64'd4,        0, 3);
    expectTxn(0, "st last",     0, 1, 64'h3F8, 64'h1234,     64'd4,        0, 3);
    expectTxn(0, "ld last",     1, 0, 64'h3F8, 64'h0,        64'h1234,     0, 3);

    // Req held through Busy: only the first is answered, the second goes in after Ack
    setReq(0, 1'b1, 1'b1, 1'b0, 64'h8, 64'h0);
    @(posedge Clock); #1;
    busA.Address = 64'h10;
    for (int c = 1; c <= 7; c++) begin
      checkVal($sformatf("hold ack c%0d", c), 64'(busA.Ack), (c == 3 || c == 7) ? 64'd1 : 64'd0);
      if (c == 3) checkVal("hold first data", busA.ReadData, 64'd1);
      if (c == 4) checkVal("hold idle busy", 64'(busA.Busy), 64'd0);
      if (c == 7) begin
        checkVal("hold second data", busA.ReadData, 64'd2);
        setReq(0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0);
      end
      @(posedge Clock); #1;
    end
    checkVal("hold end busy", 64'(busA.Busy), 64'd0);
    @(posedge Clock); #1;
    checkVal("hold no third", 64'(busA.Busy), 64'd0);

    // Reset during WAIT discards the store
    setReq(0, 1'b1, 1'b0, 1'b1, 64'h10, 64'hAAAA);
    @(posedge Clock); #1;
    setReq(0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0);
    checkVal("rst pre busy", 64'(busA.Busy), 64'd1);
    Reset = 1'b1;
    @(posedge Clock); #1;
    checkVal("rst busy", 64'(busA.Busy), 64'd0);
    checkVal("rst ack", 64'(busA.Ack), 64'd0);
    checkVal("rst data", busA.ReadData, 64'd0);
    Reset = 1'b0;
    ackSeen = 1'b0;
    repeat (4) begin
      @(posedge Clock); #1;
      ackSeen |= busA.Ack;
    end
    checkVal("rst no ack", 64'(ackSeen), 64'd0);
    expectTxn(0, "ld 0x10 after rst", 1, 0, 64'h10, 64'h0, 64'd2, 0, 3);

    // Zero wait states, back to back
    expectTxn(1, "B ld 0x8",  1, 0, 64'h8,  64'h0, 64'd1, 0, 1);
    expectTxn(1, "B ld 0x10", 1, 0, 64'h10, 64'h0, 64'd2, 0, 1);

    // One wait state, base 0x100, 16 doublewords
    expectTxn(2, "C below base", 1, 0, 64'hF8,  64'h0, 64'd0,  1, 2);
    expectTxn(2, "C ld base",    1, 0, 64'h100, 64'h0, 64'd0,  0, 2);
    expectTxn(2, "C ld last",    1, 0, 64'h178, 64'h0, 64'd15, 0, 2);
    expectTxn(2, "C above top",  1, 0, 64'h180, 64'h0, 64'd0,  1, 2);
    expectTxn(2, "C ld base+8",  1, 0, 64'h108, 64'h0, 64'd1,  0, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

endmodule
